// File: rtl/onchip_mem_stream_reader_pkg.sv
// Shared constants for the on-chip memory stream reader: CSR map, register bit positions
// and FSM state encoding.
package onchip_mem_stream_reader_pkg;

  localparam logic [1:0] CsrStartAddr = 2'd0;
  localparam logic [1:0] CsrLength    = 2'd1;
  localparam logic [1:0] CsrControl   = 2'd2;
  localparam logic [1:0] CsrStatus    = 2'd3;

  localparam int unsigned CtrlGoBit    = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlAbortBit = 2;

  localparam int unsigned StatBusyBit = 0;
  localparam int unsigned StatDoneBit = 1;
  localparam int unsigned StatErrBit  = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/stream_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data and a synchronous flush.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module stream_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Reads a programmed span of a 1-cycle-latency on-chip memory and emits it as one
// Avalon-ST packet; CSR slave for setup, status and completion interrupt.
module onchip_mem_stream_reader
  import onchip_mem_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_startofpacket,
  output logic              st_endofpacket,
  output logic              irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] start_addr_q, addr_q, addr_d;
  logic [LEN_W-1:0]  length_q, issue_cnt_q, issue_cnt_d, pop_cnt_q, pop_cnt_d;
  logic              irq_en_q, done_q, err_q, inflight_q, sop_q, sop_d;
  logic [31:0]       csr_readdata_q, csr_readdata_d;

  logic              busy, csr_wr, wr_start, wr_len, wr_ctrl, wr_status, go_wr, abort_wr;
  logic              issue, flush, pop, push, done_set, err_set;
  logic              fifo_empty, unused_fifo_full, unused_wdata;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     occupancy;

  assign busy      = (state_q != StIdle);
  assign csr_wr    = csr_chipselect & csr_write;
  assign wr_start  = csr_wr & (csr_address == CsrStartAddr);
  assign wr_len    = csr_wr & (csr_address == CsrLength);
  assign wr_ctrl   = csr_wr & (csr_address == CsrControl);
  assign wr_status = csr_wr & (csr_address == CsrStatus);
  assign abort_wr  = wr_ctrl & csr_writedata[CtrlAbortBit];
  // ABORT takes priority over GO when both bits are set in one write.
  assign go_wr     = wr_ctrl & csr_writedata[CtrlGoBit] & ~csr_writedata[CtrlAbortBit];
  assign unused_wdata = ^csr_writedata[31:LEN_W];

  // Reserve FIFO room for the word still coming back from memory.
  assign occupancy = {1'b0, fifo_count} + (CntW + 1)'(inflight_q);

  assign pop  = st_valid & st_ready;
  assign push = inflight_q & ~flush;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    sop_d       = sop_q;
    issue       = 1'b0;
    flush       = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_wr) begin
          if (length_q == '0) begin
            done_set = 1'b1;
            err_set  = 1'b1;
          end else begin
            addr_d      = start_addr_q;
            issue_cnt_d = length_q;
            pop_cnt_d   = length_q;
            sop_d       = 1'b1;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (issue_cnt_q != '0 && occupancy < (CntW + 1)'(FIFO_DEPTH)) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q - LEN_W'(1);
        end
        if (issue_cnt_d == '0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop_cnt_q == '0) begin
          done_set = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      pop_cnt_d = pop_cnt_d - LEN_W'(1);
      sop_d     = 1'b0;
    end
    if (abort_wr && busy) begin
      issue       = 1'b0;
      flush       = 1'b1;
      done_set    = 1'b0;
      err_set     = 1'b1;
      issue_cnt_d = '0;
      pop_cnt_d   = '0;
      sop_d       = 1'b0;
      state_d     = StIdle;
    end
  end

  always_comb begin
    csr_readdata_d = '0;
    unique case (csr_address)
      CsrStartAddr: csr_readdata_d = 32'(start_addr_q);
      CsrLength:    csr_readdata_d = 32'(length_q);
      CsrControl:   csr_readdata_d[CtrlIrqEnBit] = irq_en_q;
      CsrStatus: begin
        csr_readdata_d[StatBusyBit] = busy;
        csr_readdata_d[StatDoneBit] = done_q;
        csr_readdata_d[StatErrBit]  = err_q;
      end
      default: csr_readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      issue_cnt_q    <= '0;
      pop_cnt_q      <= '0;
      sop_q          <= 1'b0;
      inflight_q     <= 1'b0;
      start_addr_q   <= '0;
      length_q       <= '0;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      csr_readdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      sop_q       <= sop_d;
      inflight_q  <= issue;
      if (wr_start && !busy) start_addr_q <= csr_writedata[ADDR_W-1:0];
      if (wr_len && !busy)   length_q     <= csr_writedata[LEN_W-1:0];
      if (wr_ctrl)           irq_en_q     <= csr_writedata[CtrlIrqEnBit];
      if (done_set) begin
        done_q <= 1'b1;
      end else if ((go_wr && !busy) || (wr_status && csr_writedata[StatDoneBit])) begin
        done_q <= 1'b0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (wr_status && csr_writedata[StatErrBit]) begin
        err_q <= 1'b0;
      end
      if (csr_chipselect && csr_read) csr_readdata_q <= csr_readdata_d;
    end
  end

  stream_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (mem_readdata),
    .pop       (pop),
    .pop_data  (st_data),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign st_valid         = ~fifo_empty;
  assign st_startofpacket = st_valid & sop_q;
  assign st_endofpacket   = st_valid & (pop_cnt_q == LEN_W'(1));
  assign csr_readdata     = csr_readdata_q;
  assign mem_address      = addr_q;
  assign mem_chipselect   = issue;
  assign mem_write        = 1'b0;
  assign mem_byteenable   = 4'hF;
  assign mem_clken        = 1'b1;
  assign irq              = done_q & irq_en_q;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench: behavioural 1-cycle-latency memory, scoreboard queues of expected
// addresses and stream beats filled when a transfer is launched.
module tb_onchip_mem_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  csr_address;
  logic        csr_chipselect, csr_write, csr_read;
  logic [31:0] csr_writedata, csr_readdata;
  logic [12:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic [31:0] st_data;
  logic        st_valid, st_ready, st_startofpacket, st_endofpacket, irq;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [12:0] addr_q[$];
  int checks = 0, errors = 0;
  int cycle = 0, issues = 0, beats = 0, valid_cycles = 0;
  int first_issue = 0, last_issue = 0;
  bit arm_first = 0;

  always #5 clk = ~clk;

  onchip_mem_stream_reader dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .csr_address      (csr_address),
    .csr_chipselect   (csr_chipselect),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_read         (csr_read),
    .csr_readdata     (csr_readdata),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_byteenable   (mem_byteenable),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .st_data          (st_data),
    .st_valid         (st_valid),
    .st_ready         (st_ready),
    .st_startofpacket (st_startofpacket),
    .st_endofpacket   (st_endofpacket),
    .irq              (irq)
  );

  function automatic logic [31:0] mem_word(input logic [12:0] a);
    return 32'hC0DE_0000 ^ {a, 3'b101, a, 3'b011};
  endfunction

  always @(posedge clk) mem_readdata <= mem_word(mem_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every memory request and accepted beat against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      cycle++;
      if (st_valid) valid_cycles++;
      if (mem_chipselect) begin
        if (arm_first) begin
          first_issue = cycle;
          arm_first   = 0;
        end
        last_issue = cycle;
        issues++;
        checks++;
        assert (addr_q.size() != 0) else begin
          errors++;
          $error("FAIL mem_addr_extra observed=0x%04h expected=none", mem_address);
        end
        if (addr_q.size() != 0) check("mem_addr", 32'(mem_address), 32'(addr_q.pop_front()));
      end
      if (st_valid && st_ready) begin
        beats++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL beat_extra observed=0x%08h expected=none", st_data);
        end
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("st_data", st_data, e.data);
          check("st_sop", 32'(st_startofpacket), 32'(e.sop));
          check("st_eop", 32'(st_endofpacket), 32'(e.eop));
        end
      end
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_chipselect = 1; csr_write = 1; csr_address = a; csr_writedata = d;
    @(posedge clk); #1;
    csr_chipselect = 0; csr_write = 0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_chipselect = 1; csr_read = 1; csr_address = a;
    @(posedge clk); #1;
    csr_chipselect = 0; csr_read = 0;
    d = csr_readdata;
  endtask

  task automatic expect_xfer(input logic [12:0] start, input int len);
    for (int i = 0; i < len; i++) begin
      logic [12:0] a;
      a = start + 13'(i);
      addr_q.push_back(a);
      exp_q.push_back({mem_word(a), (i == 0), (i == len - 1)});
    end
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < 400 && s[0]; i++) csr_rd(2'd3, s);
    check({tag, "_idle"}, 32'(s[0]), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int base_i, base_b, base_v;
    reset_n = 0; csr_address = 0; csr_chipselect = 0; csr_write = 0;
    csr_writedata = 0; csr_read = 0; st_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_st_valid", 32'(st_valid), 0);
    check("rst_mem_cs", 32'(mem_chipselect), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rdata", csr_readdata, 0);
    reset_n = 1;
    @(posedge clk); #1;
    csr_rd(2'd3, d);
    check("rst_status", d, 0);

    // Basic transfer, latency and back-to-back issue.
    csr_wr(2'd0, 32'h010);
    csr_wr(2'd1, 32'd4);
    expect_xfer(13'h010, 4);
    base_i = issues; arm_first = 1;
    csr_wr(2'd2, 32'h3);
    @(posedge clk); #1;
    check("t1_valid_early", 32'(st_valid), 0);
    @(posedge clk); #1;
    check("t1_valid_first", 32'(st_valid), 1);
    wait_idle("t1");
    csr_rd(2'd3, d);
    check("t1_status", d, 32'h2);
    check("t1_irq", 32'(irq), 1);
    check("t1_issues", issues - base_i, 4);
    check("t1_consecutive", last_issue - first_issue, 3);
    check("t1_drained", exp_q.size(), 0);

    // Address wrap at the top of memory.
    csr_wr(2'd3, 32'h2);
    check("t2_irq_clr", 32'(irq), 0);
    csr_wr(2'd0, 32'h1FFE);
    csr_wr(2'd1, 32'd4);
    expect_xfer(13'h1FFE, 4);
    csr_wr(2'd2, 32'h3);
    wait_idle("t2");
    csr_rd(2'd3, d);
    check("t2_status", d, 32'h2);
    check("t2_drained", exp_q.size() + addr_q.size(), 0);

    // Backpressure: reads stall at FIFO depth.
    csr_wr(2'd3, 32'h2);
    st_ready = 0;
    csr_wr(2'd0, 32'h200);
    csr_wr(2'd1, 32'd16);
    expect_xfer(13'h200, 16);
    base_i = issues; base_b = beats;
    csr_wr(2'd2, 32'h3);
    repeat (10) @(posedge clk);
    #1;
    check("t3_stall_issues", issues - base_i, 4);
    check("t3_stall_valid", 32'(st_valid), 1);
    check("t3_stall_sop", 32'(st_startofpacket), 1);
    st_ready = 1;
    wait_idle("t3");
    check("t3_beats", beats - base_b, 16);
    check("t3_drained", exp_q.size(), 0);

    // Zero length.
    csr_wr(2'd3, 32'h2);
    csr_wr(2'd1, 32'd0);
    base_i = issues; base_v = valid_cycles;
    csr_wr(2'd2, 32'h1);
    csr_rd(2'd3, d);
    check("t4_status", d, 32'h6);
    repeat (3) @(posedge clk);
    #1;
    csr_rd(2'd3, d);
    check("t4_status_late", d, 32'h6);
    check("t4_no_issue", issues - base_i, 0);
    check("t4_no_valid", valid_cycles - base_v, 0);
    check("t4_irq_off", 32'(irq), 0);

    // Abort mid-packet, then a clean restart.
    csr_wr(2'd3, 32'h6);
    csr_wr(2'd0, 32'h100);
    csr_wr(2'd1, 32'd100);
    expect_xfer(13'h100, 100);
    base_b = beats;
    csr_wr(2'd2, 32'h3);
    for (int i = 0; i < 300 && (beats - base_b) < 20; i++) begin
      @(posedge clk); #1;
    end
    check("t5_reached20", 32'((beats - base_b) >= 20), 1);
    csr_wr(2'd2, 32'h4);
    check("t5_valid_off", 32'(st_valid), 0);
    exp_q.delete(); addr_q.delete();
    csr_rd(2'd3, d);
    check("t5_status", d, 32'h4);
    check("t5_irq", 32'(irq), 0);
    check("t5_no_stray", 32'(st_valid | mem_chipselect), 0);
    csr_wr(2'd3, 32'h4);
    csr_wr(2'd0, 32'h40);
    csr_wr(2'd1, 32'd8);
    expect_xfer(13'h040, 8);
    csr_wr(2'd2, 32'h3);
    wait_idle("t5r");
    csr_rd(2'd3, d);
    check("t5r_status", d, 32'h2);
    check("t5r_drained", exp_q.size(), 0);

    // Busy-time LENGTH write ignored; async reset mid-transfer.
    csr_wr(2'd3, 32'h2);
    csr_wr(2'd0, 32'h300);
    csr_wr(2'd1, 32'd50);
    expect_xfer(13'h300, 50);
    csr_wr(2'd2, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    csr_wr(2'd1, 32'd5);
    csr_rd(2'd1, d);
    check("t6_len_kept", d, 32'd50);
    @(posedge clk);
    #3 reset_n = 0;
    #1;
    check("t6_rst_valid", 32'(st_valid), 0);
    check("t6_rst_cs", 32'(mem_chipselect), 0);
    check("t6_rst_irq", 32'(irq), 0);
    check("t6_rst_rdata", csr_readdata, 0);
    exp_q.delete(); addr_q.delete();
    @(posedge clk); #1;
    reset_n = 1;
    csr_rd(2'd1, d);
    check("t6_len_reset", d, 0);
    csr_rd(2'd3, d);
    check("t6_status_reset", d, 0);
    check("t6_no_resume", 32'(st_valid | mem_chipselect), 0);
    csr_wr(2'd0, 32'h7);
    csr_wr(2'd1, 32'd3);
    expect_xfer(13'h007, 3);
    csr_wr(2'd2, 32'h3);
    wait_idle("t6");
    csr_rd(2'd3, d);
    check("t6_status", d, 32'h2);
    check("t6_irq", 32'(irq), 1);
    check("t6_drained", exp_q.size() + addr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
